// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: sequences init, auto-refresh, write and read
// sub-controllers onto the shared pins and owns the refresh interval timer.
module sdram_arbiter #(
  parameter int REF_PERIOD = 750,
  parameter int CNT_W      = 10
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  output logic        aref_en,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        aref_pend,
  output logic        ref_overrun,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_e;

  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

  state_e           state_q, state_d;
  logic             last_wr_q, last_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             aref_en_q, wr_en_q, rd_en_q;
  logic             ref_fire;

  // Refresh interval timer: frozen at zero until init completes
  always_comb begin
    ref_fire = (state_q != S_INIT) && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + CNT_W'(1);
    if (state_q == S_INIT || ref_fire) begin
      cnt_d = '0;
    end

    pend_d = pend_q;
    if (ref_fire) begin
      pend_d = 1'b1;
    end else if (state_q == S_AREF && aref_end) begin
      pend_d = 1'b0;
    end

    ovr_d = ovr_q | (ref_fire & pend_q);
  end

  // Grant FSM; last_wr_q records whether write won the most recent data grant
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      S_INIT: begin
        if (init_end) state_d = S_ARBIT;
      end
      S_ARBIT: begin
        if (pend_q) begin
          state_d = S_AREF;
        end else if (wr_req && rd_req) begin
          if (last_wr_q) begin
            state_d   = S_READ;
            last_wr_d = 1'b0;
          end else begin
            state_d   = S_WRITE;
            last_wr_d = 1'b1;
          end
        end else if (wr_req) begin
          state_d   = S_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = S_READ;
          last_wr_d = 1'b0;
        end
      end
      S_AREF: begin
        if (aref_end) state_d = S_ARBIT;
      end
      S_WRITE: begin
        if (wr_end) state_d = S_ARBIT;
      end
      S_READ: begin
        if (rd_end) state_d = S_ARBIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state_q   <= S_INIT;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      aref_en_q <= (state_d == S_AREF);
      wr_en_q   <= (state_d == S_WRITE);
      rd_en_q   <= (state_d == S_READ);
    end
  end

  // Pin mux is purely combinational on the registered state
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign aref_pend   = pend_q;
  assign ref_overrun = ovr_q;
  assign state       = state_q;

endmodule
